// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT corner-turn buffer.
//   FFT_N / FFT_DW     : default line length and complex sample width
//   FFT_LOG2N / FFT_AW : row/column index width and frame address width
//   FFT_RE_* / FFT_IM_*: bit positions of the real and imaginary halves
//   ct_state_t         : buffer phase (filling from rows / draining by columns)
package fft_pkg;
  localparam int FFT_N     = 128;
  localparam int FFT_DW    = 64;
  localparam int FFT_LOG2N = $clog2(FFT_N);
  localparam int FFT_AW    = 2 * FFT_LOG2N;

  localparam int FFT_RE_LSB = 0;
  localparam int FFT_RE_MSB = FFT_DW / 2 - 1;
  localparam int FFT_IM_LSB = FFT_DW / 2;
  localparam int FFT_IM_MSB = FFT_DW - 1;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } ct_state_t;
endpackage

// File: rtl/corner_turn_ram.sv
// Frame store for the corner-turn buffer: simple dual-port RAM with one
// write port and one registered read port, shaped for block-RAM inference.
// Storage is deliberately not reset.
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/rd_addr    : read request; rd_data is valid the cycle after rd_en
module corner_turn_ram
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int AW = FFT_AW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/fft_corner_turn.sv
// AXI4-Stream corner-turn buffer between a row FFT and a column FFT.
// Accepts one N x N frame in row order, then replays it column by column.
//   clk, rst                : clock, synchronous active-high reset
//   s_axis_data_*           : row-ordered input stream (slave)
//   m_axis_data_*           : column-ordered output stream (master),
//                             tlast marks the last sample of each column
//   frame_done              : pulse the cycle after the final output beat
//   err_tlast_unexpected    : pulse, input tlast on a non-final column
//   err_tlast_missing       : pulse, final column accepted without tlast
module fft_corner_turn
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int DW = FFT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_axis_data_tdata,
  input  logic          s_axis_data_tvalid,
  output logic          s_axis_data_tready,
  input  logic          s_axis_data_tlast,
  output logic [DW-1:0] m_axis_data_tdata,
  output logic          m_axis_data_tvalid,
  input  logic          m_axis_data_tready,
  output logic          m_axis_data_tlast,
  output logic          frame_done,
  output logic          err_tlast_unexpected,
  output logic          err_tlast_missing
);
  localparam int LOG2N = $clog2(N);
  localparam int AW    = 2 * LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(N - 1);
  localparam logic [AW-1:0]    LAST_BEAT = AW'(N * N - 1);

  ct_state_t        state_reg, state_next;
  logic             s_ready_reg;
  logic [LOG2N-1:0] wrow_reg, wcol_reg;
  logic             err_u_reg, err_m_reg;
  logic             frame_done_reg;

  // read side: issue counter, RAM-output tracking, 2-entry skid FIFO
  logic [AW-1:0]    rd_cnt_reg;
  logic             rd_issued_all_reg;
  logic             ram_vld_reg, ram_last_reg;
  logic             head_reg, tail_reg;
  logic [1:0]       cnt_reg;
  logic [AW-1:0]    out_cnt_reg;

  logic             accept, pop, final_pop, push, rd_en;
  logic             wrow_last, wcol_last;
  logic [2:0]       occ;
  logic [LOG2N-1:0] rd_row, rd_col;
  logic [DW-1:0]    ram_rd_data;

  assign wrow_last = (wrow_reg == LAST_IDX);
  assign wcol_last = (wcol_reg == LAST_IDX);

  // Output beat k reads row k%N of column k/N: low counter bits pick the row.
  assign rd_row = rd_cnt_reg[LOG2N-1:0];
  assign rd_col = rd_cnt_reg[AW-1:LOG2N];
  assign push   = ram_vld_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WRITE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    final_pop  = 1'b0;
    rd_en      = 1'b0;
    pop        = (cnt_reg != 2'd0) && m_axis_data_tready;
    // Entries that will sit in the FIFO after this edge, ignoring a read
    // issued now. A new read lands one cycle later, so it is only safe
    // while this is at most one (a pop next cycle is not assumed).
    occ        = {1'b0, cnt_reg} + {2'b00, ram_vld_reg};
    if (pop) begin
      occ = occ - 3'd1;
    end
    case (state_reg)
      WRITE: begin
        accept = s_axis_data_tvalid && s_ready_reg;
        if (accept && wrow_last && wcol_last) begin
          state_next = READ;
        end
      end
      READ: begin
        final_pop = pop && (out_cnt_reg == LAST_BEAT);
        rd_en     = !rd_issued_all_reg && (occ <= 3'd1);
        if (final_pop) begin
          state_next = WRITE;
        end
      end
      default: state_next = WRITE;
    endcase
  end

  // Write side: count-driven addressing; tlast only feeds the error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_reg    <= 1'b0;
      wrow_reg       <= '0;
      wcol_reg       <= '0;
      err_u_reg      <= 1'b0;
      err_m_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      s_ready_reg    <= (state_next == WRITE);
      err_u_reg      <= accept && s_axis_data_tlast && !wcol_last;
      err_m_reg      <= accept && !s_axis_data_tlast && wcol_last;
      frame_done_reg <= final_pop;
      if (accept) begin
        wcol_reg <= wcol_reg + 1'b1;
        if (wcol_last) begin
          wrow_reg <= wrow_reg + 1'b1;
        end
      end
    end
  end

  // Read side bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_reg        <= '0;
      rd_issued_all_reg <= 1'b0;
      ram_vld_reg       <= 1'b0;
      ram_last_reg      <= 1'b0;
      head_reg          <= 1'b0;
      tail_reg          <= 1'b0;
      cnt_reg           <= 2'd0;
      out_cnt_reg       <= '0;
    end else begin
      ram_vld_reg  <= rd_en;
      ram_last_reg <= rd_en && (rd_row == LAST_IDX);
      if (rd_en) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
        if (rd_cnt_reg == LAST_BEAT) begin
          rd_issued_all_reg <= 1'b1;
        end
      end
      if (final_pop) begin
        rd_issued_all_reg <= 1'b0;
      end
      if (push) begin
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg    <= ~head_reg;
        out_cnt_reg <= out_cnt_reg + 1'b1;
      end
      cnt_reg <= cnt_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Skid entries; the head entry drives the output directly so data and
  // tlast stay stable while the downstream stalls.
  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    logic [DW-1:0] data_reg;
    logic          last_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg <= '0;
        last_reg <= 1'b0;
      end else if (push && (tail_reg == 1'(gi))) begin
        data_reg <= ram_rd_data;
        last_reg <= ram_last_reg;
      end
    end
  end

  corner_turn_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr({wrow_reg, wcol_reg}),
    .wr_data(s_axis_data_tdata),
    .rd_en  (rd_en),
    .rd_addr({rd_row, rd_col}),
    .rd_data(ram_rd_data)
  );

  assign s_axis_data_tready   = s_ready_reg;
  assign m_axis_data_tvalid   = (cnt_reg != 2'd0);
  assign m_axis_data_tdata    = head_reg ? g_skid[1].data_reg : g_skid[0].data_reg;
  assign m_axis_data_tlast    = head_reg ? g_skid[1].last_reg : g_skid[0].last_reg;
  assign frame_done           = frame_done_reg;
  assign err_tlast_unexpected = err_u_reg;
  assign err_tlast_missing    = err_m_reg;
endmodule

// File: tb/tb_fft_corner_turn.sv
// Self-checking bench for fft_corner_turn (N=16 instance).
// A driver writes row-ordered frames; a frame model builds the expected
// column-major sequence into a queue; a monitor pops and compares on every
// output handshake, and also checks stall stability, latency, framing pulses.
module tb_fft_corner_turn;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int HW = DW / 2;
  localparam int NN = N * N;
  localparam int BOUND = 8 * NN + 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          frame_done;
  logic          err_u, err_m;

  fft_corner_turn #(.N(N), .DW(DW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_data_tdata   (s_tdata),
    .s_axis_data_tvalid  (s_tvalid),
    .s_axis_data_tready  (s_tready),
    .s_axis_data_tlast   (s_tlast),
    .m_axis_data_tdata   (m_tdata),
    .m_axis_data_tvalid  (m_tvalid),
    .m_axis_data_tready  (m_tready),
    .m_axis_data_tlast   (m_tlast),
    .frame_done          (frame_done),
    .err_tlast_unexpected(err_u),
    .err_tlast_missing   (err_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          fin;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] model_mem [N][N];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;       // 0: downstream always ready, 1: random 50%
  int exp_eu = 0, exp_em = 0, got_eu = 0, got_em = 0;
  int last_in_cyc = 0;
  int out_beats = 0;
  int frames_done = 0;
  bit read_phase = 0;
  bit seen_first = 0;
  bit done_exp = 0;
  bit stall_prev = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst) begin
      seen_first = 0;
      done_exp   = 0;
      stall_prev = 0;
    end else begin
      if (frame_done || done_exp) chk("frame_done_pulse", frame_done, done_exp);
      done_exp = 0;
      if (frame_done) begin
        frames_done++;
        $display("frame %0d out complete at cycle %0d", frames_done, cyc);
      end
      if (err_u) got_eu++;
      if (err_m) got_em++;
      if (read_phase) chk("s_tready_low_in_read", s_tready, 1'b0);
      if (stall_prev) begin
        chk("stall_tvalid", m_tvalid, 1'b1);
        chk("stall_tdata", m_tdata, prev_data);
        chk("stall_tlast", m_tlast, prev_last);
      end
      if (m_tvalid && !seen_first) begin
        chk("first_valid_latency", cyc - last_in_cyc, 2);
        seen_first = 1;
      end else if (seen_first && ready_mode == 0) begin
        chk("contiguous_tvalid", m_tvalid, 1'b1);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tdata", m_tdata, mon_e.data);
          chk("tlast", m_tlast, mon_e.last);
          out_beats++;
          if (mon_e.fin) begin
            done_exp   = 1;
            seen_first = 0;
            read_phase = 0;
          end
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  function automatic logic [DW-1:0] word(input int re);
    int im;
    im = ~re;
    return {im[HW-1:0], re[HW-1:0]};
  endfunction

  // Expected output: the stored frame read column by column.
  task automatic push_expected();
    exp_t e;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) begin
        e.data = model_mem[r][c];
        e.last = (r == N - 1);
        e.fin  = (r == N - 1) && (c == N - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input int base, input bit gaps, input bit rnd_data,
                            input int bad_u, input int bad_m, input bit garbage);
    int row, col, t, f0;
    logic [DW-1:0] d;
    logic tl;
    f0 = frames_done;
    for (int i = 0; i < NN; i++) begin
      row = i / N;
      col = i % N;
      d   = rnd_data ? DW'($urandom) : word(base + i);
      tl  = (col == N - 1);
      if (i == bad_u) tl = 1'b1;
      if (i == bad_m) tl = 1'b0;
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_tdata = d; s_tlast = tl; s_tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_tready && t < BOUND) begin
        t++;
        @(negedge clk);
      end
      if (!s_tready) begin
        chk("input_accept_timeout", 0, 1);
        s_tvalid = 1'b0;
        return;
      end
      model_mem[row][col] = d;
      if (tl && col != N - 1) exp_eu++;
      if (!tl && col == N - 1) exp_em++;
      if (i == NN - 1) begin
        last_in_cyc = cyc + 1;
        push_expected();
      end
      @(posedge clk); #1;
    end
    read_phase = 1;
    if (garbage) begin
      // Keep offering beats while the frame drains; none may be taken.
      t = 0;
      while (t < BOUND) begin
        s_tdata  = DW'($urandom);
        s_tlast  = 1'($urandom_range(0, 1));
        s_tvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (frame_done || frames_done != f0) break;
        t++;
      end
      s_tvalid = 1'b0;
      @(posedge clk); #1;
    end else begin
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic wait_done(input int tgt);
    int t;
    t = 0;
    while (frames_done < tgt && t < BOUND) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("frame_done_seen", frames_done >= tgt, 1);
  endtask

  task automatic check_frame_end(input string tag);
    chk("err_unexpected_count", got_eu, exp_eu);
    chk("err_missing_count", got_em, exp_em);
    chk("queue_drained", exp_q.size(), 0);
    chk("s_tready_after_frame", s_tready, 1'b1);
    $display("%s: checks=%0d errors=%0d", tag, checks, errors);
    got_eu = 0; got_em = 0; exp_eu = 0; exp_em = 0;
  endtask

  int tgt;
  int t;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_err_u", err_u, 1'b0);
    chk("rst_err_m", err_m, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s_tready_after_release", s_tready, 1'b1);

    // 1: ramp frame, downstream always ready
    ready_mode = 0;
    tgt = frames_done + 1;
    send_frame(0, 0, 0, -1, -1, 0);
    wait_done(tgt);
    check_frame_end("scenario1");

    // 2: same frame, random backpressure
    ready_mode = 1;
    tgt = frames_done + 1;
    send_frame(0, 0, 0, -1, -1, 0);
    wait_done(tgt);
    check_frame_end("scenario2");

    // 3: stray tlast on row 5 col 9, missing tlast on row 7 col N-1
    ready_mode = 0;
    tgt = frames_done + 1;
    send_frame(0, 0, 0, 5 * N + 9, 7 * N + N - 1, 0);
    wait_done(tgt);
    check_frame_end("scenario3");

    // 4: reset in the middle of the output phase, then a fresh frame
    ready_mode = 1;
    out_beats = 0;
    send_frame(7, 0, 0, -1, -1, 0);
    t = 0;
    while (out_beats < 100 && t < BOUND) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("reached_100_beats", out_beats >= 100, 1);
    rst = 1'b1;
    exp_q.delete();
    read_phase = 0;
    @(posedge clk); #1;
    chk("midrst_m_tvalid", m_tvalid, 1'b0);
    chk("midrst_m_tlast", m_tlast, 1'b0);
    chk("midrst_s_tready", s_tready, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    got_eu = 0; got_em = 0; exp_eu = 0; exp_em = 0;
    @(posedge clk); #1;
    chk("midrst_s_tready_release", s_tready, 1'b1);
    tgt = frames_done + 1;
    send_frame(5, 0, 0, -1, -1, 0);
    wait_done(tgt);
    check_frame_end("scenario4");

    // 5: input gaps, random data, upstream pushing during READ; two frames
    for (int f = 0; f < 2; f++) begin
      tgt = frames_done + 1;
      send_frame(0, 1, 1, -1, -1, 1);
      wait_done(tgt);
      check_frame_end("scenario5");
    end

    // 6: contiguous drain with ready held high after the busy traffic
    ready_mode = 0;
    tgt = frames_done + 1;
    send_frame(1000, 1, 0, -1, -1, 0);
    wait_done(tgt);
    check_frame_end("scenario6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
